// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_if
//  Purpose  : Handshake/bus bundle between the fetch stage, the fetch queue
//             and the decode stage.
//  Modports : slave  - the fetch queue (captures fetches, presents head entry)
//             master - the surrounding pipeline (drives fetch/pop/flush)
//  Signals  : flush_i, push_i, pc_i[31:0], instr_i[31:0], pop_i   (to queue)
//             valid_o, pc_o[31:0], pc4_o[31:0], instr_o[31:0],
//             full_o, count_o[CW-1:0], overflow_o                 (from queue)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int CW = 3
);
  logic          flush_i;
  logic          push_i;
  logic [31:0]   pc_i;
  logic [31:0]   instr_i;
  logic          pop_i;
  logic          valid_o;
  logic [31:0]   pc_o;
  logic [31:0]   pc4_o;
  logic [31:0]   instr_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  modport slave (
    input  flush_i, push_i, pc_i, instr_i, pop_i,
    output valid_o, pc_o, pc4_o, instr_o, full_o, count_o, overflow_o
  );

  modport master (
    output flush_i, push_i, pc_i, instr_i, pop_i,
    input  valid_o, pc_o, pc4_o, instr_o, full_o, count_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : First-word-fall-through instruction fetch buffer sitting between
//             the PC/instruction-memory stage and the IF/ID decode input.
//             Holds {pc, instruction} pairs, absorbs decode stalls and drops
//             everything on a taken branch/jump (flush).
//  Ports    : clk_i  - clock, rising edge
//             rst_i  - asynchronous reset, active low
//             fq     - fetch_queue_if.slave bundle
//                        flush_i/push_i/pc_i/instr_i/pop_i in,
//                        valid_o/pc_o/pc4_o/instr_o/full_o/count_o/overflow_o out
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter int          CW    = 3,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  fetch_queue_if.slave     fq
);

  localparam int PW = $clog2(DEPTH);

  // Storage: {pc, instr} per entry; contents need no reset.
  logic [63:0]   mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic [63:0]   head;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // A pop on an empty queue is ignored; a full queue accepts a push only
  // when the head leaves in the same cycle. Pushing into an empty queue with
  // a concurrent pop is not bypassed: the pop is simply ignored.
  assign do_pop  = fq.pop_i & ~empty;
  assign do_push = fq.push_i & (~full | do_pop);

  assign head    = mem[rd_ptr];

  // Zero-latency head presentation; idle values when nothing is held.
  assign fq.valid_o    = ~empty;
  assign fq.pc_o       = empty ? 32'h0 : head[63:32];
  assign fq.instr_o    = empty ? NOP   : head[31:0];
  assign fq.pc4_o      = fq.pc_o + 32'd4;
  assign fq.full_o     = full;
  assign fq.count_o    = count;
  assign fq.overflow_o = overflow;

  // Data path: a flush discards the same-cycle push, so the write is gated.
  always_ff @(posedge clk_i) begin
    if (do_push && !fq.flush_i) begin
      mem[wr_ptr] <= {fq.pc_i, fq.instr_i};
    end
  end

  // Control path. DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (fq.flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
      // Debug flag only: the PC write-enable should already be held off by
      // full_o, so a dropped push indicates an integration error.
      if (fq.push_i && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. Stimulus pushes expected
//             {pc, instr} pairs into a scoreboard queue as the fetch side is
//             driven; an independent monitor compares the presented head entry
//             against the scoreboard on every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          CW    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic clk;
  logic rst_n;
  bit   done;

  int n_cmp;
  int n_err;

  logic [63:0] sb[$];
  bit          m_ovf;

  fetch_queue_if #(.CW(CW)) fq ();

  fetch_queue #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .NOP   (NOP)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (got timeout, required finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: compares the head entry with the scoreboard each falling edge
  // and retires the scoreboard entry when decode accepts it.
  always @(negedge clk) begin
    if (!done) begin
      if (fq.valid_o) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL head_unexpected: got pc %h required no valid entry", fq.pc_o);
        end else begin
          check("head_pc",    {32'h0, fq.pc_o},    {32'h0, sb[0][63:32]});
          check("head_instr", {32'h0, fq.instr_o}, {32'h0, sb[0][31:0]});
          check("head_pc4",   {32'h0, fq.pc4_o},   {32'h0, sb[0][63:32] + 32'd4});
          if (fq.pop_i && !fq.flush_i) void'(sb.pop_front());
        end
      end else begin
        check("idle_entries", 64'(sb.size()), 64'd0);
        check("idle_instr", {32'h0, fq.instr_o}, {32'h0, NOP});
        check("idle_pc4",   {32'h0, fq.pc4_o},   64'h4);
      end
    end
  end

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input logic f, input logic p, input logic [31:0] pc,
                      input logic [31:0] ins, input logic q);
    int cnt;
    bit dpop;
    bit dpush;
    fq.flush_i = f;
    fq.push_i  = p;
    fq.pc_i    = pc;
    fq.instr_i = ins;
    fq.pop_i   = q;
    cnt   = sb.size();
    dpop  = q && (cnt != 0);
    dpush = p && ((cnt != DEPTH) || dpop);
    @(posedge clk);
    if (f) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (dpush) sb.push_back({pc, ins});
      if (p && !dpush) m_ovf = 1'b1;
    end
    #1;
    fq.flush_i = 1'b0;
    fq.push_i  = 1'b0;
    fq.pc_i    = 32'h0;
    fq.instr_i = 32'h0;
    fq.pop_i   = 1'b0;
    check("count",    64'(fq.count_o), 64'(sb.size()));
    check("overflow", 64'(fq.overflow_o), 64'(m_ovf));
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    step(1'b0, 1'b1, pc, ins, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic fill(input logic [31:0] base);
    push(base + 32'd0,  32'h2001000A);
    push(base + 32'd4,  32'h2002000B);
    push(base + 32'd8,  32'h00221820);
    push(base + 32'd12, 32'hAC030000);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_ovf = 1'b0;
    done  = 1'b0;
    rst_n = 1'b0;
    fq.flush_i = 1'b0;
    fq.push_i  = 1'b0;
    fq.pc_i    = 32'h0;
    fq.instr_i = 32'h0;
    fq.pop_i   = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(fq.valid_o), 64'd0);
    check("rst_instr", {32'h0, fq.instr_o}, 64'h0);
    check("rst_pc",    {32'h0, fq.pc_o}, 64'h0);
    check("rst_pc4",   {32'h0, fq.pc4_o}, 64'h4);
    check("rst_count", 64'(fq.count_o), 64'd0);
    check("rst_full",  64'(fq.full_o), 64'd0);
    check("rst_ovf",   64'(fq.overflow_o), 64'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Fill and drain.
    fill(32'h0);
    check("fill_count", 64'(fq.count_o), 64'd4);
    check("fill_full",  64'(fq.full_o), 64'd1);
    check("fill_pc",    {32'h0, fq.pc_o}, 64'h0);
    check("fill_instr", {32'h0, fq.instr_o}, 64'h2001000A);
    repeat (4) pop();
    check("drain_valid", 64'(fq.valid_o), 64'd0);

    // Full with simultaneous push+pop; pc 16 lands after a pointer wrap.
    fill(32'h0);
    step(1'b0, 1'b1, 32'd16, 32'h1111_2222, 1'b1);
    check("pp_count", 64'(fq.count_o), 64'd4);
    check("pp_head",  {32'h0, fq.pc_o}, 64'h4);
    repeat (4) pop();
    check("pp_empty", 64'(fq.valid_o), 64'd0);

    // Hazard stall: head must hold while a third entry arrives.
    push(32'h100, 32'hA0A0_0001);
    push(32'h104, 32'hA0A0_0002);
    push(32'h108, 32'hA0A0_0003);
    check("stall_pc1", {32'h0, fq.pc_o}, 64'h100);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("stall_pc2", {32'h0, fq.pc_o}, 64'h100);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("stall_pc3",    {32'h0, fq.pc_o}, 64'h100);
    check("stall_instr",  {32'h0, fq.instr_o}, 64'hA0A0_0001);
    check("stall_count",  64'(fq.count_o), 64'd3);

    // Flush collides with push and pop; pc 0x40 must never surface.
    step(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1);
    check("flush_count", 64'(fq.count_o), 64'd0);
    check("flush_valid", 64'(fq.valid_o), 64'd0);
    check("flush_instr", {32'h0, fq.instr_o}, {32'h0, NOP});
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Push+pop on empty: no bypass, the pop is ignored.
    step(1'b0, 1'b1, 32'h200, 32'h0000_0200, 1'b1);
    check("nb_count", 64'(fq.count_o), 64'd1);
    check("nb_pc",    {32'h0, fq.pc_o}, 64'h200);
    pop();

    // Pop on empty is ignored.
    pop();
    check("pop_empty_count", 64'(fq.count_o), 64'd0);

    // Overflow: dropped push sets the sticky flag, data unchanged.
    fill(32'h300);
    push(32'h400, 32'h0000_0400);
    check("ovf_flag",  64'(fq.overflow_o), 64'd1);
    check("ovf_count", 64'(fq.count_o), 64'd4);
    check("ovf_head",  {32'h0, fq.pc_o}, 64'h300);
    pop();
    check("ovf_sticky", 64'(fq.overflow_o), 64'd1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check("ovf_clear", 64'(fq.overflow_o), 64'd0);

    // pc4 wraps modulo 2^32.
    push(32'hFFFF_FFFC, 32'h0000_0013);
    check("wrap_pc4", {32'h0, fq.pc4_o}, 64'h0);
    pop();

    // Asynchronous reset mid-operation.
    push(32'h500, 32'h0000_0500);
    push(32'h504, 32'h0000_0504);
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    check("arst_valid", 64'(fq.valid_o), 64'd0);
    check("arst_count", 64'(fq.count_o), 64'd0);
    check("arst_pc4",   {32'h0, fq.pc4_o}, 64'h4);
    #1;
    rst_n = 1'b1;
    push(32'h600, 32'h0000_0600);
    check("arst_first_push", 64'(fq.count_o), 64'd1);
    check("arst_first_pc",   {32'h0, fq.pc_o}, 64'h600);
    pop();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
